// File: rtl/and_net_sequencer_pkg.sv
// Shared constants for the AND-network sequencer: sizes, FSM states,
// operand-select encoding and the node evaluation schedule.
package and_net_sequencer_pkg;

  localparam int NUM_NODES  = 11;
  localparam int NUM_INPUTS = 4;
  localparam int SEL_W      = 4;
  localparam int STEP_W     = 4;
  localparam int BUS_W      = 2 ** SEL_W;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_NODES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COMP,
    COPY,
    UNC,
    DONE
  } state_t;

  // Selects 0-3 pick a,b,c,d; selects 4-14 pick scratch nodes n5..n15.
  localparam logic [SEL_W-1:0] SEL_A   = 4'd0;
  localparam logic [SEL_W-1:0] SEL_B   = 4'd1;
  localparam logic [SEL_W-1:0] SEL_C   = 4'd2;
  localparam logic [SEL_W-1:0] SEL_D   = 4'd3;
  localparam logic [SEL_W-1:0] SEL_N5  = 4'd4;
  localparam logic [SEL_W-1:0] SEL_N6  = 4'd5;
  localparam logic [SEL_W-1:0] SEL_N13 = 4'd12;

  typedef struct packed {
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic [STEP_W-1:0] target;
  } sched_t;

  // Targets are scratch indices (0 = n5 ... 10 = n15); every operand node
  // appears earlier than its consumer, so a reverse walk uncomputes cleanly.
  localparam sched_t SCHEDULE [NUM_NODES] = '{
    '{SEL_A,   SEL_B, 4'd0},
    '{SEL_N5,  SEL_C, 4'd1},
    '{SEL_N6,  SEL_D, 4'd2},
    '{SEL_N5,  SEL_D, 4'd3},
    '{SEL_A,   SEL_C, 4'd4},
    '{SEL_A,   SEL_D, 4'd5},
    '{SEL_B,   SEL_C, 4'd6},
    '{SEL_B,   SEL_D, 4'd7},
    '{SEL_C,   SEL_D, 4'd8},
    '{SEL_N13, SEL_A, 4'd9},
    '{SEL_N13, SEL_B, 4'd10}
  };

endpackage

// File: rtl/and_net_sequencer_step.sv
// Shared 2-input AND unit: selects two operands, ANDs them and XORs the
// result into one scratch node.
module and_step_unit
  import and_net_sequencer_pkg::*;
(
  input  logic [NUM_INPUTS-1:0] operand,
  input  logic [NUM_NODES-1:0]  scratch,
  input  logic [SEL_W-1:0]      sel_a,
  input  logic [SEL_W-1:0]      sel_b,
  input  logic [STEP_W-1:0]     target,
  input  logic                  clear,
  output logic [NUM_NODES-1:0]  scratch_next
);

  localparam int PAD_W = BUS_W - NUM_NODES - NUM_INPUTS;

  logic [BUS_W-1:0]     operand_bus;
  logic [NUM_NODES-1:0] base;
  logic                 and_bit;

  assign operand_bus = {{PAD_W{1'b0}}, scratch, operand};
  assign and_bit     = operand_bus[sel_a] & operand_bus[sel_b];
  // Clearing happens underneath the first accumulate of a run.
  assign base        = clear ? '0 : scratch;

  generate
    for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_node
      assign scratch_next[gi] = base[gi] ^ (and_bit & (target == STEP_W'(gi)));
    end
  endgenerate

endmodule

// File: rtl/and_net_sequencer.sv
// Sequencer that evaluates an 11-node AND network one node per cycle,
// copies the result out and optionally uncomputes the scratch registers.
module and_net_sequencer
  import and_net_sequencer_pkg::*;
#(
  parameter int UNCOMPUTE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_INPUTS-1:0] in_vec,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_NODES-1:0]  out_vec,
  output logic                  scratch_clean
);

  state_t                state_reg, state_next;
  logic [STEP_W-1:0]     step_reg, step_next;
  logic [NUM_INPUTS-1:0] operand_reg, operand_next;
  logic [NUM_NODES-1:0]  scratch_reg, scratch_next;
  logic [NUM_NODES-1:0]  out_reg, out_next;
  logic [NUM_NODES-1:0]  unit_result;
  logic                  unit_clear;
  sched_t                entry;

  assign entry = SCHEDULE[step_reg];

  and_step_unit u_step (
    .operand      (operand_reg),
    .scratch      (scratch_reg),
    .sel_a        (entry.sel_a),
    .sel_b        (entry.sel_b),
    .target       (entry.target),
    .clear        (unit_clear),
    .scratch_next (unit_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      step_reg    <= '0;
      operand_reg <= '0;
      scratch_reg <= '0;
      out_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      step_reg    <= step_next;
      operand_reg <= operand_next;
      scratch_reg <= scratch_next;
      out_reg     <= out_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    step_next    = step_reg;
    operand_next = operand_reg;
    scratch_next = scratch_reg;
    out_next     = out_reg;
    unit_clear   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = COMP;
          operand_next = in_vec;
          step_next    = '0;
        end
      end
      COMP: begin
        unit_clear   = (step_reg == '0);
        scratch_next = unit_result;
        // Step is left at the last entry so the uncompute walk starts there.
        if (step_reg == LAST_STEP) begin
          state_next = COPY;
        end else begin
          step_next = step_reg + 1'b1;
        end
      end
      COPY: begin
        out_next   = scratch_reg;
        state_next = (UNCOMPUTE != 0) ? UNC : DONE;
      end
      UNC: begin
        scratch_next = unit_result;
        if (step_reg == '0) begin
          state_next = DONE;
        end else begin
          step_next = step_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign out_vec       = out_reg;
  assign scratch_clean = (scratch_reg == '0);

endmodule

// File: tb/tb_and_net_sequencer.sv
// Scoreboard bench for and_net_sequencer: one instance with uncompute,
// one without; a monitor checks every done pulse against queued results.
module tb_and_net_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic [3:0]  in1 = '0, in0 = '0;
  logic        busy1, done1, clean1, busy0, done0, clean0;
  logic [10:0] out1, out0;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    logic [10:0] out;
    int          cyc;
    logic        clean;
  } exp_t;

  exp_t exp1[$];
  exp_t exp0[$];

  logic [3:0]  dir_vec [6] = '{4'b1111, 4'b0011, 4'b1100, 4'b0101, 4'b0111, 4'b1011};
  logic [10:0] dir_exp [6] = '{11'h7FF, 11'h001, 11'h100, 11'h010, 11'h053, 11'h0A9};

  and_net_sequencer #(.UNCOMPUTE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_vec(in1),
    .busy(busy1), .done(done1), .out_vec(out1), .scratch_clean(clean1)
  );

  and_net_sequencer #(.UNCOMPUTE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_vec(in0),
    .busy(busy0), .done(done0), .out_vec(out0), .scratch_clean(clean0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] golden(input logic [3:0] v);
    logic a, b, c, d, n5, n6, n7, n8, n9, n10, n11, n12, n13, n14, n15;
    a = v[0]; b = v[1]; c = v[2]; d = v[3];
    n5 = a & b;  n6 = n5 & c; n7 = n6 & d; n8 = n5 & d;
    n9 = a & c;  n10 = a & d; n11 = b & c; n12 = b & d;
    n13 = c & d; n14 = n13 & a; n15 = n13 & b;
    return {n15, n14, n13, n12, n11, n10, n9, n8, n7, n6, n5};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1) begin
        if (exp1.size() == 0) begin
          total++;
          $display("FAIL spurious_done1: actual done=1 required done=0 at cycle %0d", cyc);
        end else begin
          e = exp1.pop_front();
          check("out_vec1", 32'(out1), 32'(e.out));
          check("latency1", 32'(cyc - e.cyc), 32'd23);
          check("clean1", 32'(clean1), 32'(e.clean));
        end
      end
      if (done0) begin
        if (exp0.size() == 0) begin
          total++;
          $display("FAIL spurious_done0: actual done=1 required done=0 at cycle %0d", cyc);
        end else begin
          e = exp0.pop_front();
          check("out_vec0", 32'(out0), 32'(e.out));
          check("latency0", 32'(cyc - e.cyc), 32'd12);
          check("clean0", 32'(clean0), 32'(e.clean));
        end
      end
    end
  endtask

  // Called at a falling edge; start is sampled by the following rising edge.
  task automatic issue1(input logic [3:0] v, input logic [10:0] e_out, input logic push);
    exp_t e;
    if (push) begin
      e.out = e_out; e.cyc = cyc + 1; e.clean = 1'b1;
      exp1.push_back(e);
    end
    in1 = v; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic issue0(input logic [3:0] v, input logic [10:0] e_out);
    exp_t e;
    e.out = e_out; e.cyc = cyc + 1; e.clean = (e_out == '0);
    exp0.push_back(e);
    in0 = v; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done(input logic which, input int budget);
    int n;
    n = 0;
    while (!(which ? done0 : done1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(which ? done0 : done1)) begin
      total++;
      $display("FAIL wait_done%0d: actual no done within %0d cycles required done", which, budget);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_out1", 32'(out1), 32'd0);
    check("rst_clean1", 32'(clean1), 32'd1);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_out0", 32'(out0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue1(dir_vec[i], dir_exp[i], 1'b1);
      check("busy1_running", 32'(busy1), 32'd1);
      wait_done(1'b0, 40);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("out1_hold", 32'(out1), 32'h0A9);

    // Second start mid-run must be ignored.
    issue1(4'b0011, 11'h001, 1'b1);
    repeat (3) @(negedge clk);
    in1 = 4'b1100; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, 40);
    repeat (30) @(negedge clk);

    // Reset in the middle of COMP aborts the run.
    issue1(4'b1111, 11'h000, 1'b0);
    repeat (5) @(negedge clk);
    check("clean1_midrun", 32'(clean1), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy1", 32'(busy1), 32'd0);
    check("abort_out1", 32'(out1), 32'd0);
    check("abort_clean1", 32'(clean1), 32'd1);
    check("abort_done1", 32'(done1), 32'd0);
    repeat (30) @(negedge clk);
    issue1(4'b1111, 11'h7FF, 1'b1);
    wait_done(1'b0, 40);
    @(negedge clk);

    // No uncompute: scratch stays populated until the next COMP starts.
    issue0(4'b1111, 11'h7FF);
    wait_done(1'b1, 40);
    repeat (5) @(negedge clk);
    check("clean0_retained", 32'(clean0), 32'd0);
    check("out0_hold", 32'(out0), 32'h7FF);
    issue0(4'b0000, 11'h000);
    check("clean0_first_comp", 32'(clean0), 32'd0);
    @(negedge clk);
    check("clean0_cleared", 32'(clean0), 32'd1);
    wait_done(1'b1, 40);
    @(negedge clk);
    issue0(4'b0101, 11'h010);
    wait_done(1'b1, 40);
    @(negedge clk);

    // Back-to-back sweep: each start lands in the IDLE cycle after DONE.
    for (int v = 0; v < 16; v++) begin
      issue1(4'(v), golden(4'(v)), 1'b1);
      wait_done(1'b0, 40);
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue1_drained", 32'(exp1.size()), 32'd0);
    check("queue0_drained", 32'(exp0.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/and_net_sequencer.md
AND_NET_SEQUENCER -- requirements
Module: and_net_sequencer

Interface
REQ-001 Parameter UNCOMPUTE, default 1, meaning: 1 = run Bennett-style uncompute phase after copy-out; 0 = skip it and leave scratch populated.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request one evaluation; sampled only in IDLE.
REQ-005 in_vec  input  4  operands; in_vec[0..3] = a,b,c,d; captured on accepted start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 out_vec  output  11  result nodes n5..n15 on bits [0..10].
REQ-009 scratch_clean  output  1  high when all 11 scratch node registers are zero.

Function
REQ-010 Node set SHALL be: n5=a&b, n6=n5&c, n7=n6&d, n8=n5&d, n9=a&c, n10=a&d, n11=b&c, n12=b&d, n13=c&d, n14=n13&a, n15=n13&b.
REQ-011 One shared 2-input AND unit SHALL evaluate exactly one node per cycle; a fixed 11-entry schedule ROM SHALL supply the two operand selects and the target, in order n5..n15.
REQ-012 The FSM SHALL have states IDLE, COMP, COPY, UNC, DONE.
REQ-013 IDLE -> COMP on start=1, capturing in_vec into the operand register and setting step=0.
REQ-014 COMP SHALL XOR the AND result into scratch[target], increment step, and go to COPY after step 10.
REQ-015 COPY SHALL load out_vec from scratch in one cycle; next state is UNC if UNCOMPUTE=1, else DONE.
REQ-016 UNC SHALL walk the schedule in reverse (step 10 down to 0), XORing the recomputed AND into scratch[target], then go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-018 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E0+23 (UNCOMPUTE=1) or E0+12 (UNCOMPUTE=0).
REQ-019 start while busy SHALL be ignored, with no effect on in_vec capture, step or outputs.
REQ-020 start in the cycle after DONE (IDLE) SHALL be accepted normally; back-to-back runs are allowed.
REQ-021 out_vec SHALL hold its value from COPY until the next COPY or reset.
REQ-022 With UNCOMPUTE=1, scratch_clean SHALL be 1 in DONE for every input.
REQ-023 With UNCOMPUTE=0, scratch SHALL retain node values until the next COMP begins.
REQ-024 COMP SHALL clear scratch on its first cycle before accumulating.

Reset
REQ-025 rst=1 SHALL force, at the next edge: state IDLE, step 0, operand register 0, scratch all 0, out_vec 0, busy 0, done 0, scratch_clean 1.
REQ-026 rst asserted in any state mid-operation SHALL abort the run with no done pulse, and the outputs SHALL take the values in REQ-025.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 A shared package SHALL hold: NUM_NODES=11, NUM_INPUTS=4, the state enum, the operand-select encoding (0-3 inputs, 4-14 nodes) and the schedule ROM constant.
REQ-029 One sub-module, and_step_unit, SHALL implement operand muxing, the AND, and the XOR-accumulate into the target.

Verification
REQ-030 in_vec=4'b1111, UNCOMPUTE=1 -> out_vec=11'h7FF; done after E0+23; scratch_clean=1 at done.
REQ-031 in_vec=4'b0011 -> out_vec=11'h001 (n5 only); in_vec=4'b1100 -> out_vec=11'h100 (n13 only); in_vec=4'b0101 -> out_vec=11'h010 (n9 only).
REQ-032 start pulsed again at COMP step 3 with different in_vec -> ignored; result matches the first in_vec; exactly one done.
REQ-033 rst asserted at COMP step 5 -> next cycle busy=0, out_vec=0, scratch_clean=1; no done; a fresh start then completes correctly.
REQ-034 UNCOMPUTE=0, in_vec=4'b1111 -> done after E0+12; scratch_clean=0 until the next start.
REQ-035 Exhaustive sweep of all 16 in_vec values with back-to-back starts -> out_vec matches the REQ-010 golden model for every value.
